cnt12_checker: RTL and testbench
================================

Name: cnt12_checker

Overview:
- Passive protocol monitor for the mod-12 up/down counter interface (ud in, q[3:0] out).
- Samples ud and q on every clock, predicts each next q, and locks onto the count sequence.
- Flags mismatches, illegal codes and bad reset values; counts errors and reports wrap events.
- Instantiated in benches and in-system alongside cnt12, sharing its clk and reset.

Parameters:
- MODULUS, 12, count modulus (legal q = 0..MODULUS-1)
- WIDTH, 4, width of q
- LOCK_LEN, 4, consecutive correct transitions needed to lock
- ERR_W, 8, width of error counter
- RELOCK, 1, 1: return to SYNC after an error; 0: enter FAULT and hold until clear_err

Ports:
- clk  input  1  rising-edge clock, same as counter
- reset  input  1  asynchronous, active-high reset
- ud  input  1  direction observed at counter (1 up, 0 down)
- q  input  WIDTH  counter output being checked
- clear_err  input  1  synchronous clear of err_sticky/err_count; exits FAULT
- locked  output  1  high while in TRACK
- err_pulse  output  1  one-cycle pulse per detected error
- err_sticky  output  1  set on any error, held until clear_err
- err_count  output  ERR_W  saturating error count
- illegal  output  1  one-cycle pulse when q >= MODULUS is sampled
- rst_err  output  1  one-cycle pulse if first post-reset sample of q != 0
- wrap_up  output  1  one-cycle pulse on verified 11->0 with ud=1
- wrap_dn  output  1  one-cycle pulse on verified 0->11 with ud=0
- expected  output  WIDTH  predicted q for the current cycle (valid when locked)

Behaviour:
- Reset (async assert, released synchronously on the next edge): state=SYNC, first=1, lock_cnt=0, all outputs 0, q_prev=0, ud_prev=0.
- Prediction: pred = ud_prev ? (q_prev==MODULUS-1 ? 0 : q_prev+1) : (q_prev==0 ? MODULUS-1 : q_prev-1). Compute in WIDTH+1 bits, no silent truncation.
- Each edge (not in reset): sample q/ud, compare q with pred, then update q_prev<=q, ud_prev<=ud.
- Latency: every flag is registered and asserts on the edge that samples the offending or qualifying q (visible 1 cycle after q changes).
- First sample after reset:
  - q must equal 0; else rst_err=1 and err_pulse=1, counted as an error.
  - No pred compare on this sample. first<=0.
- SYNC state:
  - match -> lock_cnt+1; reaching LOCK_LEN -> TRACK, locked<=1.
  - mismatch or illegal -> lock_cnt<=0; no err_pulse (only illegal/rst_err pulse).
- TRACK state:
  - mismatch or q>=MODULUS -> err_pulse=1, err_sticky<=1, err_count+1 (saturates at 2^ERR_W-1), locked<=0, lock_cnt<=0.
  - After an error: next state SYNC if RELOCK=1, else FAULT.
  - Matching q==0 with q_prev==11, ud_prev=1 -> wrap_up. Matching q==11 with q_prev==0, ud_prev=0 -> wrap_dn.
- FAULT state:
  - No checking, locked=0, sticky held.
  - clear_err -> SYNC with lock_cnt=0.
- expected = pred while locked, else 0.
- clear_err coinciding with an error: the error wins. Result err_count=1, err_sticky=1.
- Reset mid-run: all state returns to reset values immediately (async). err_count and err_sticky are cleared.
- Direction change (ud toggles): legal. Prediction always uses the ud sampled with q_prev.

Decomposition:
- Shared package cnt12_pkg:
  - MODULUS and WIDTH constants.
  - chk_state_t enum {SYNC, TRACK, FAULT}.
  - Function next_count(q, ud), the single source of mod-12 arithmetic, reusable by cnt12.
- No sub-module needed: one FSM plus counters in a single module.

Test Plan:
- Counter up 15 cycles from reset (ud=1) -> locked rises after 4 transitions, wrap_up pulses once on the 11->0 edge, err_count=0.
- Switch ud=0 mid-count at q=5 -> next q=4 accepted. Run past 0 -> wrap_dn on the 0->11 edge, no errors.
- Force q to 7 when 4 is expected while locked -> err_pulse 1 cycle, err_sticky=1, err_count=1, locked=0, relocks after 4 good transitions.
- Force q=13 while locked -> illegal and err_pulse in the same cycle, err_count increments.
- RELOCK=0, inject error -> FAULT and locked stays 0. Pulse clear_err -> err_count=0, sticky=0, relock in 4 cycles. With clear_err and error in the same cycle -> err_count=1.
- Hold q=3 at reset release -> rst_err=1, err_count=1. Assert reset mid-TRACK -> all outputs 0 immediately. Inject 300 errors -> err_count saturates at 255.

Source files
------------

// File: rtl/cnt12_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnt12_pkg
// Purpose  : Shared constants, checker state encoding and mod-12 next-count
//            arithmetic for the cnt12 counter and its protocol checker.
// Revision : 1.0  initial release
// ============================================================================
package cnt12_pkg;

    localparam int MODULUS = 12;
    localparam int WIDTH   = 4;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } chk_state_t;

    // Result is one bit wider than the count so an out-of-range input (e.g. 15
    // counting up) yields a visibly illegal value instead of wrapping to 0.
    function automatic logic [WIDTH:0] next_count(input logic [WIDTH-1:0] cur,
                                                  input logic             up);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] res;
        ext = {1'b0, cur};
        if (up) begin
            res = (ext == (WIDTH+1)'(MODULUS-1)) ? '0 : ext + (WIDTH+1)'(1);
        end else begin
            res = (ext == '0) ? (WIDTH+1)'(MODULUS-1) : ext - (WIDTH+1)'(1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt12_checker.sv
`default_nettype none
// ============================================================================
// Module   : cnt12_checker
// Purpose  : Passive monitor for the mod-12 up/down counter; locks onto the
//            count sequence and flags mismatches, illegal codes, bad resets.
// Revision : 1.0  initial release
// ============================================================================
module cnt12_checker #(
    parameter int MODULUS  = cnt12_pkg::MODULUS,
    parameter int WIDTH    = cnt12_pkg::WIDTH,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8,
    parameter bit RELOCK   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ud,
    input  logic [WIDTH-1:0] q,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic             illegal,
    output logic             rst_err,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic [WIDTH-1:0] expected
);
    import cnt12_pkg::*;

    localparam int LC_W = $clog2(LOCK_LEN + 1);

    chk_state_t       state_q, state_d;
    logic             first_q, first_d;
    logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [WIDTH-1:0] q_prev_q, q_prev_d;
    logic             ud_prev_q, ud_prev_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             illegal_q, illegal_d;
    logic             rst_err_q, rst_err_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_dn_q, wrap_dn_d;

    logic [WIDTH:0]   pred;
    logic             is_illegal;
    logic             is_match;
    logic             err_event;

    always_comb begin
        pred       = next_count(q_prev_q, ud_prev_q);
        is_illegal = ({1'b0, q} >= (WIDTH+1)'(MODULUS));
        is_match   = !is_illegal && ({1'b0, q} == pred);

        state_d      = state_q;
        first_d      = 1'b0;
        lock_cnt_d   = lock_cnt_q;
        q_prev_d     = q;
        ud_prev_d    = ud;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        illegal_d    = 1'b0;
        rst_err_d    = 1'b0;
        wrap_up_d    = 1'b0;
        wrap_dn_d    = 1'b0;
        err_event    = 1'b0;

        if (clear_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end

        if (first_q) begin
            illegal_d = is_illegal;
            if (q != '0) begin
                rst_err_d = 1'b1;
                err_event = 1'b1;
            end
        end else begin
            case (state_q)
                SYNC: begin
                    illegal_d = is_illegal;
                    if (is_match) begin
                        lock_cnt_d = lock_cnt_q + LC_W'(1);
                        if (lock_cnt_q + LC_W'(1) == LC_W'(LOCK_LEN)) begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                TRACK: begin
                    illegal_d = is_illegal;
                    if (!is_match) begin
                        err_event  = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                        state_d    = RELOCK ? SYNC : FAULT;
                    end else begin
                        wrap_up_d = ud_prev_q && (q_prev_q == WIDTH'(MODULUS-1));
                        wrap_dn_d = !ud_prev_q && (q_prev_q == '0);
                    end
                end
                FAULT: begin
                    if (clear_err) begin
                        state_d    = SYNC;
                        lock_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = SYNC;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                end
            endcase
        end

        // An error in the same cycle as clear_err lands on the cleared value.
        if (err_event) begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            if (err_count_d != '1) begin
                err_count_d = err_count_d + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SYNC;
            first_q      <= 1'b1;
            lock_cnt_q   <= '0;
            q_prev_q     <= '0;
            ud_prev_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            illegal_q    <= 1'b0;
            rst_err_q    <= 1'b0;
            wrap_up_q    <= 1'b0;
            wrap_dn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            lock_cnt_q   <= lock_cnt_d;
            q_prev_q     <= q_prev_d;
            ud_prev_q    <= ud_prev_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            illegal_q    <= illegal_d;
            rst_err_q    <= rst_err_d;
            wrap_up_q    <= wrap_up_d;
            wrap_dn_q    <= wrap_dn_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign illegal    = illegal_q;
    assign rst_err    = rst_err_q;
    assign wrap_up    = wrap_up_q;
    assign wrap_dn    = wrap_dn_q;
    assign expected   = locked_q ? pred[WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_cnt12_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt12_checker
// Purpose  : Directed self-checking bench for cnt12_checker (RELOCK=1 and
//            RELOCK=0 instances fed from the same counter stimulus).
// Revision : 1.0  initial release
// ============================================================================
module tb_cnt12_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ud = 1'b1;
    logic [3:0] q = 4'd0;
    logic       clear_err = 1'b0;

    logic       locked, err_pulse, err_sticky, illegal, rst_err, wrap_up, wrap_dn;
    logic [7:0] err_count;
    logic [3:0] expected;

    logic       locked2, err_pulse2, err_sticky2, illegal2, rst_err2, wrap_up2, wrap_dn2;
    logic [7:0] err_count2;
    logic [3:0] expected2;

    int n_checks = 0;
    int n_errors = 0;
    int wu_cnt   = 0;
    int wd_cnt   = 0;
    int cur;

    always #5 clk = ~clk;

    cnt12_checker #(.RELOCK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .ud(ud), .q(q), .clear_err(clear_err),
        .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_count(err_count), .illegal(illegal), .rst_err(rst_err),
        .wrap_up(wrap_up), .wrap_dn(wrap_dn), .expected(expected)
    );

    cnt12_checker #(.RELOCK(1'b0)) u_dut_fault (
        .clk(clk), .reset(reset), .ud(ud), .q(q), .clear_err(clear_err),
        .locked(locked2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
        .err_count(err_count2), .illegal(illegal2), .rst_err(rst_err2),
        .wrap_up(wrap_up2), .wrap_dn(wrap_dn2), .expected(expected2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one counter value, then sample just after the edge that takes it.
    task automatic drive(input int qv, input logic udv);
        q  = 4'(qv);
        ud = udv;
        @(posedge clk);
        #1;
        if (wrap_up) wu_cnt++;
        if (wrap_dn) wd_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        wu_cnt = 0;
        wd_cnt = 0;
    endtask

    function automatic int mod_up(input int v);
        return (v == 11) ? 0 : v + 1;
    endfunction

    initial begin
        // Reset state
        do_reset();
        check_val("rst_locked", locked, 0);
        check_val("rst_err_pulse", err_pulse, 0);
        check_val("rst_sticky", err_sticky, 0);
        check_val("rst_count", err_count, 0);
        check_val("rst_expected", expected, 0);
        check_val("rst_rst_err", rst_err, 0);

        // Count up from 0: lock after 4 transitions, one wrap at 11->0
        drive(0, 1'b1);
        check_val("first_ok_rst_err", rst_err, 0);
        check_val("first_ok_pulse", err_pulse, 0);
        for (int v = 1; v <= 3; v++) drive(v, 1'b1);
        check_val("not_locked_3", locked, 0);
        drive(4, 1'b1);
        check_val("locked_4", locked, 1);
        check_val("expected_5", expected, 5);
        for (int v = 5; v <= 11; v++) drive(v, 1'b1);
        drive(0, 1'b1);
        check_val("wrap_up_pulse", wrap_up, 1);
        drive(1, 1'b1);
        check_val("wrap_up_gone", wrap_up, 0);
        drive(2, 1'b1);
        check_val("wrap_up_count", wu_cnt, 1);
        check_val("up_err_count", err_count, 0);

        // Direction change at 5, then count down through 0 -> 11
        drive(3, 1'b1);
        drive(4, 1'b1);
        drive(5, 1'b0);
        drive(4, 1'b0);
        check_val("dir_change_pulse", err_pulse, 0);
        check_val("dir_change_locked", locked, 1);
        for (int v = 3; v >= 0; v--) drive(v, 1'b0);
        drive(11, 1'b0);
        check_val("wrap_dn_pulse", wrap_dn, 1);
        drive(10, 1'b0);
        check_val("wrap_dn_count", wd_cnt, 1);
        check_val("wrap_up_none_down", wu_cnt, 1);
        check_val("down_err_count", err_count, 0);

        // Forced mismatch while locked, then relock
        for (int v = 9; v >= 5; v--) drive(v, 1'b0);
        check_val("expected_4", expected, 4);
        drive(7, 1'b0);
        check_val("mm_pulse", err_pulse, 1);
        check_val("mm_sticky", err_sticky, 1);
        check_val("mm_count", err_count, 1);
        check_val("mm_locked", locked, 0);
        check_val("mm_expected", expected, 0);
        drive(6, 1'b0);
        check_val("mm_pulse_1cyc", err_pulse, 0);
        drive(5, 1'b0);
        drive(4, 1'b0);
        check_val("relock_not_yet", locked, 0);
        drive(3, 1'b0);
        check_val("relock", locked, 1);

        // Illegal code while locked
        drive(13, 1'b0);
        check_val("ill_illegal", illegal, 1);
        check_val("ill_pulse", err_pulse, 1);
        check_val("ill_count", err_count, 2);
        drive(5, 1'b0);
        check_val("sync_mm_no_pulse", err_pulse, 0);
        check_val("ill_1cyc", illegal, 0);
        check_val("sync_mm_count", err_count, 2);
        for (int v = 4; v >= 1; v--) drive(v, 1'b0);
        check_val("ill_relock", locked, 1);

        // clear_err while tracking without error
        clear_err = 1'b1;
        drive(0, 1'b0);
        clear_err = 1'b0;
        check_val("clr_count", err_count, 0);
        check_val("clr_sticky", err_sticky, 0);
        check_val("clr_locked", locked, 1);

        // Asynchronous reset mid-TRACK
        drive(11, 1'b0);
        reset = 1'b1;
        #1;
        check_val("async_locked", locked, 0);
        check_val("async_wrap_dn", wrap_dn, 0);
        check_val("async_expected", expected, 0);
        q  = 4'd3;
        ud = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        wu_cnt = 0;
        wd_cnt = 0;

        // Bad value at reset release
        drive(3, 1'b1);
        check_val("bad_rst_rst_err", rst_err, 1);
        check_val("bad_rst_pulse", err_pulse, 1);
        check_val("bad_rst_count", err_count, 1);
        check_val("bad_rst_sticky", err_sticky, 1);
        drive(4, 1'b1);
        check_val("bad_rst_1cyc", rst_err, 0);

        // 300 injected errors: lock, then skip a count
        cur = 4;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) begin
                cur = mod_up(cur);
                drive(cur, 1'b1);
            end
            cur = mod_up(mod_up(cur));
            drive(cur, 1'b1);
            if (i == 9) check_val("count_11", err_count, 11);
        end
        check_val("sat_count", err_count, 255);
        check_val("sat_sticky", err_sticky, 1);

        // RELOCK=0 instance: FAULT hold and clear
        do_reset();
        for (int v = 0; v <= 4; v++) drive(v, 1'b1);
        check_val("f_locked", locked2, 1);
        drive(7, 1'b1);
        check_val("f_pulse", err_pulse2, 1);
        check_val("f_count", err_count2, 1);
        for (int v = 8; v <= 11; v++) drive(v, 1'b1);
        drive(0, 1'b1);
        check_val("f_stays_unlocked", locked2, 0);
        drive(5, 1'b1);
        check_val("f_no_check_pulse", err_pulse2, 0);
        check_val("f_no_check_count", err_count2, 1);
        check_val("f_sticky_held", err_sticky2, 1);
        clear_err = 1'b1;
        drive(6, 1'b1);
        clear_err = 1'b0;
        check_val("f_clr_count", err_count2, 0);
        check_val("f_clr_sticky", err_sticky2, 0);
        for (int v = 7; v <= 9; v++) drive(v, 1'b1);
        check_val("f_relock_not_yet", locked2, 0);
        drive(10, 1'b1);
        check_val("f_relock", locked2, 1);
        clear_err = 1'b1;
        drive(3, 1'b1);
        clear_err = 1'b0;
        check_val("f_clr_vs_err_count", err_count2, 1);
        check_val("f_clr_vs_err_sticky", err_sticky2, 1);
        check_val("f_clr_vs_err_locked", locked2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
